// File: rtl/sensor_scanner.sv
// rtl/sensor_scanner.sv - polls four height sensors over a 4-phase req/ack bus and publishes whole frames
//
// Purpose:
//   Walks sensors 0..3 on a shared req/ack bus. Each reading goes into a shadow
//   register. The shadow values and the per-sensor fault mask are then copied to
//   the outputs in a single COMMIT cycle, so a consumer never sees a frame that
//   mixes readings from two scans. If a sensor does not answer within TIMEOUT
//   cycles in the request phase, its reading is 0 and its fault bit is set.
//   If it does not release ack within TIMEOUT cycles, its reading is kept and
//   its fault bit is set.
//
// Ports:
//   clk                 clock, rising edge
//   rst                 asynchronous reset, active-high
//   start               begin one frame (sampled only while idle)
//   busy                high whenever a frame is in progress
//   bus_sel[1:0]        index of the sensor currently addressed
//   bus_req             request to the addressed sensor
//   bus_ack             acknowledge from the addressed sensor
//   bus_data[7:0]       reading from the addressed sensor, valid with bus_ack
//   sensor1..sensor4    last committed readings
//   fault[3:0]          bit i set when sensor i+1 timed out in the last frame
//   frame_valid         one-cycle pulse, high together with the new outputs

module sensor_scanner #(
    parameter int TIMEOUT    = 15,
    parameter bit CONTINUOUS = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    output logic       busy,
    output logic [1:0] bus_sel,
    output logic       bus_req,
    input  logic       bus_ack,
    input  logic [7:0] bus_data,
    output logic [7:0] sensor1,
    output logic [7:0] sensor2,
    output logic [7:0] sensor3,
    output logic [7:0] sensor4,
    output logic [3:0] fault,
    output logic       frame_valid
);

    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_REL,
        S_COMMIT
    } state_t;

    state_t          r_state;
    logic [1:0]      r_sel;
    logic            r_req;
    logic [CW-1:0]   r_cnt;
    logic [7:0]      r_shadow [4];
    logic [3:0]      r_fshadow;
    logic [7:0]      r_sensor [4];
    logic [3:0]      r_fault;
    logic            r_fv;

    logic            w_cnt_last;

    assign w_cnt_last = (r_cnt == CNT_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_sel     <= 2'd0;
            r_req     <= 1'b0;
            r_cnt     <= '0;
            r_fshadow <= 4'd0;
            r_fault   <= 4'd0;
            r_fv      <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                r_shadow[i] <= 8'd0;
                r_sensor[i] <= 8'd0;
            end
        end else begin
            r_fv <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_sel     <= 2'd0;
                        r_req     <= 1'b1;
                        r_cnt     <= '0;
                        r_fshadow <= 4'd0;
                        r_state   <= S_REQ;
                    end
                end

                S_REQ: begin
                    // An ack arriving in the last allowed cycle still wins over the timeout.
                    if (bus_ack) begin
                        r_shadow[r_sel] <= bus_data;
                        r_req           <= 1'b0;
                        r_cnt           <= '0;
                        r_state         <= S_REL;
                    end else if (w_cnt_last) begin
                        r_shadow[r_sel]  <= 8'd0;
                        r_fshadow[r_sel] <= 1'b1;
                        r_req            <= 1'b0;
                        r_cnt            <= '0;
                        r_state          <= S_REL;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end

                S_REL: begin
                    if (!bus_ack || w_cnt_last) begin
                        // Stuck ack: keep the captured reading but flag the sensor.
                        if (bus_ack) begin
                            r_fshadow[r_sel] <= 1'b1;
                        end
                        r_cnt <= '0;
                        if (r_sel == 2'd3) begin
                            r_state <= S_COMMIT;
                        end else begin
                            r_sel   <= r_sel + 2'd1;
                            r_req   <= 1'b1;
                            r_state <= S_REQ;
                        end
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end

                S_COMMIT: begin
                    for (int i = 0; i < 4; i++) begin
                        r_sensor[i] <= r_shadow[i];
                    end
                    r_fault <= r_fshadow;
                    r_fv    <= 1'b1;
                    if (CONTINUOUS) begin
                        r_sel     <= 2'd0;
                        r_req     <= 1'b1;
                        r_cnt     <= '0;
                        r_fshadow <= 4'd0;
                        r_state   <= S_REQ;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign busy        = (r_state != S_IDLE);
    assign bus_sel     = r_sel;
    assign bus_req     = r_req;
    assign sensor1     = r_sensor[0];
    assign sensor2     = r_sensor[1];
    assign sensor3     = r_sensor[2];
    assign sensor4     = r_sensor[3];
    assign fault       = r_fault;
    assign frame_valid = r_fv;

endmodule

// File: tb/tb_sensor_scanner.sv
// tb/tb_sensor_scanner.sv - self-checking bench for sensor_scanner
module tb_sensor_scanner;

    localparam int TO = 15;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       start;
    logic       busy;
    logic [1:0] bus_sel;
    logic       bus_req;
    logic       bus_ack;
    logic [7:0] bus_data;
    logic [7:0] sensor1, sensor2, sensor3, sensor4;
    logic [3:0] fault;
    logic       frame_valid;

    logic       start2;
    logic       busy2;
    logic [1:0] sel2;
    logic       req2;
    logic       ack2;
    logic [7:0] data2;
    logic [7:0] s2_1, s2_2, s2_3, s2_4;
    logic [3:0] fault2;
    logic       fv2;

    int total = 0;
    int bad   = 0;

    sensor_scanner #(.TIMEOUT(TO), .CONTINUOUS(1'b0)) dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy),
        .bus_sel(bus_sel), .bus_req(bus_req), .bus_ack(bus_ack), .bus_data(bus_data),
        .sensor1(sensor1), .sensor2(sensor2), .sensor3(sensor3), .sensor4(sensor4),
        .fault(fault), .frame_valid(frame_valid)
    );

    sensor_scanner #(.TIMEOUT(TO), .CONTINUOUS(1'b1)) dut2 (
        .clk(clk), .rst(rst), .start(start2), .busy(busy2),
        .bus_sel(sel2), .bus_req(req2), .bus_ack(ack2), .bus_data(data2),
        .sensor1(s2_1), .sensor2(s2_2), .sensor3(s2_3), .sensor4(s2_4),
        .fault(fault2), .frame_valid(fv2)
    );

    logic [7:0] sens  [4];
    logic [7:0] sens2 [4];
    assign sens[0]  = sensor1;
    assign sens[1]  = sensor2;
    assign sens[2]  = sensor3;
    assign sens[3]  = sensor4;
    assign sens2[0] = s2_1;
    assign sens2[1] = s2_2;
    assign sens2[2] = s2_3;
    assign sens2[3] = s2_4;

    // Sensor responders: sensor i raises ack delay_cfg[i]+1 cycles into its request,
    // never answers if never_cfg[i], and with stuck_cfg[i] keeps ack high while selected.
    logic [7:0] val       [4];
    int         delay_cfg [4];
    bit         never_cfg [4];
    bit         stuck_cfg [4];
    int         rcnt      [4];
    logic       rack      [4];

    always @(negedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (rst) begin
                rcnt[i] <= 0;
                rack[i] <= 1'b0;
            end else if (bus_req && bus_sel == 2'(i)) begin
                rcnt[i] <= rcnt[i] + 1;
                if (!never_cfg[i] && (rcnt[i] + 1) > delay_cfg[i]) rack[i] <= 1'b1;
            end else begin
                rcnt[i] <= 0;
                if (!(stuck_cfg[i] && bus_sel == 2'(i))) rack[i] <= 1'b0;
            end
        end
    end

    assign bus_ack  = rack[bus_sel];
    assign bus_data = val[bus_sel];

    // The continuous instance sees sensors that answer and release at once.
    logic [7:0] val2 [4];
    assign ack2  = req2;
    assign data2 = val2[sel2];

    // Expected frame, derived from the responder behaviour and the timeout rules.
    logic [7:0] exp_s   [4];
    logic [3:0] exp_f;
    int         exp_lat;
    int         exp_req [4];

    task automatic model_frame;
        int rel;
        exp_lat = 2;
        exp_f   = 4'd0;
        for (int i = 0; i < 4; i++) begin
            if (never_cfg[i] || delay_cfg[i] >= TO) begin
                exp_req[i] = TO;
                exp_s[i]   = 8'd0;
                exp_f[i]   = 1'b1;
                rel        = 1;
            end else begin
                exp_req[i] = delay_cfg[i] + 1;
                exp_s[i]   = val[i];
                exp_f[i]   = stuck_cfg[i];
                rel        = stuck_cfg[i] ? TO : 1;
            end
            exp_lat += exp_req[i] + rel;
        end
    endtask

    task automatic set_plain(input int d);
        for (int i = 0; i < 4; i++) begin
            val[i]       = 8'($urandom_range(1, 255));
            delay_cfg[i] = d;
            never_cfg[i] = 1'b0;
            stuck_cfg[i] = 1'b0;
        end
    endtask

    task automatic run_frame(input string name, input int restart_at);
        logic [7:0] prev [4];
        logic [3:0] pf;
        int         cyc;
        bit         held;
        bit         busy_ok;
        int         rl [4];
        int         run;
        logic       rprev;
        logic [1:0] rsel;
        model_frame();
        for (int i = 0; i < 4; i++) begin
            prev[i] = sens[i];
            rl[i]   = -1;
        end
        pf      = fault;
        held    = 1'b1;
        busy_ok = 1'b1;
        run     = 0;
        rprev   = 1'b0;
        rsel    = 2'd0;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc   = 1;
        total++;
        if (!(bus_req === 1'b1 && bus_sel === 2'd0)) begin
            bad++;
            $display("FAIL %s first_req: req=%b sel=%0d want req=1 sel=0", name, bus_req, bus_sel);
        end
        while (frame_valid !== 1'b1 && cyc < 400) begin
            if (bus_req) begin
                run  = rprev ? run + 1 : 1;
                rsel = bus_sel;
            end else if (rprev) begin
                rl[rsel] = run;
            end
            rprev = bus_req;
            for (int i = 0; i < 4; i++) if (sens[i] !== prev[i]) held = 1'b0;
            if (fault !== pf) held = 1'b0;
            if (busy !== 1'b1) busy_ok = 1'b0;
            start = (cyc == restart_at);
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        total++;
        if (cyc != exp_lat) begin
            bad++;
            $display("FAIL %s latency: got %0d cycles want %0d", name, cyc, exp_lat);
        end
        for (int i = 0; i < 4; i++) begin
            total++;
            if (sens[i] !== exp_s[i]) begin
                bad++;
                $display("FAIL %s sensor%0d: got %0d want %0d", name, i + 1, sens[i], exp_s[i]);
            end
            total++;
            if (rl[i] != exp_req[i]) begin
                bad++;
                $display("FAIL %s req_len%0d: got %0d want %0d", name, i + 1, rl[i], exp_req[i]);
            end
        end
        total++;
        if (fault !== exp_f) begin
            bad++;
            $display("FAIL %s fault: got %b want %b", name, fault, exp_f);
        end
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("FAIL %s busy_at_fv: got %b want 0", name, busy);
        end
        total++;
        if (!held || !busy_ok) begin
            bad++;
            $display("FAIL %s hold_during_frame: held=%0d busy_ok=%0d want 1 1", name, held, busy_ok);
        end
        @(negedge clk);
        total++;
        if (frame_valid !== 1'b0) begin
            bad++;
            $display("FAIL %s fv_width: got %b want 0", name, frame_valid);
        end
        if (restart_at >= 0) begin
            int extra;
            extra = 0;
            for (int k = 0; k < 40; k++) begin
                if (frame_valid !== 1'b0 || busy !== 1'b0) extra++;
                @(negedge clk);
            end
            total++;
            if (extra != 0) begin
                bad++;
                $display("FAIL %s second_frame: got %0d active cycles want 0", name, extra);
            end
        end
    endtask

    task automatic test_reset;
        total++;
        if (busy !== 1'b0 || bus_req !== 1'b0 || bus_sel !== 2'd0) begin
            bad++;
            $display("FAIL reset_ctrl: busy=%b req=%b sel=%0d want 0 0 0", busy, bus_req, bus_sel);
        end
        total++;
        if ({sensor1, sensor2, sensor3, sensor4} !== 32'd0 || fault !== 4'd0) begin
            bad++;
            $display("FAIL reset_data: sensors=%h fault=%b want 0", {sensor1, sensor2, sensor3, sensor4}, fault);
        end
        total++;
        if (frame_valid !== 1'b0 || fv2 !== 1'b0 || busy2 !== 1'b0) begin
            bad++;
            $display("FAIL reset_fv: fv=%b fv2=%b busy2=%b want 0", frame_valid, fv2, busy2);
        end
    endtask

    task automatic test_basic;
        set_plain(2);
        for (int i = 0; i < 4; i++) val[i] = 8'(20 + i);
        run_frame("basic", -1);
    endtask

    task automatic test_req_timeout;
        set_plain(1);
        never_cfg[2] = 1'b1;
        run_frame("req_timeout", -1);
    endtask

    task automatic test_rel_timeout;
        set_plain(0);
        stuck_cfg[1] = 1'b1;
        run_frame("rel_timeout", -1);
    endtask

    task automatic test_start_ignored;
        set_plain(1);
        run_frame("start_busy", 5);
    endtask

    task automatic test_reset_midframe;
        int guard;
        set_plain(0);
        delay_cfg[2] = 8;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        guard = 0;
        while (!(bus_req === 1'b1 && bus_sel === 2'd2) && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        total++;
        if (guard >= 100) begin
            bad++;
            $display("FAIL midframe_reach: got guard=%0d want <100", guard);
        end
        rst = 1'b1;
        #1;
        total++;
        if (bus_req !== 1'b0 || busy !== 1'b0 || bus_sel !== 2'd0) begin
            bad++;
            $display("FAIL midframe_ctrl: req=%b busy=%b sel=%0d want 0 0 0", bus_req, busy, bus_sel);
        end
        total++;
        if ({sensor1, sensor2, sensor3, sensor4} !== 32'd0 || fault !== 4'd0 || frame_valid !== 1'b0) begin
            bad++;
            $display("FAIL midframe_data: sensors=%h fault=%b fv=%b want 0", {sensor1, sensor2, sensor3, sensor4}, fault, frame_valid);
        end
        @(negedge clk);
        rst = 1'b0;
        set_plain(0);
        run_frame("post_reset", -1);
    endtask

    task automatic test_random;
        int r;
        for (int f = 0; f < 8; f++) begin
            for (int i = 0; i < 4; i++) begin
                val[i]       = 8'($urandom_range(1, 255));
                delay_cfg[i] = $urandom_range(0, 3);
                never_cfg[i] = 1'b0;
                stuck_cfg[i] = 1'b0;
                r = $urandom_range(0, 9);
                if (r == 0) never_cfg[i] = 1'b1;
                if (r == 1) stuck_cfg[i] = 1'b1;
                if (r == 2) delay_cfg[i] = TO - 1;
                if (r == 3) delay_cfg[i] = TO;
            end
            run_frame("random", -1);
        end
    endtask

    task automatic test_continuous;
        logic [7:0] e [4];
        int cyc;
        for (int i = 0; i < 4; i++) begin
            val2[i] = 8'($urandom_range(1, 255));
            e[i]    = val2[i];
        end
        @(negedge clk);
        start2 = 1'b1;
        @(negedge clk);
        start2 = 1'b0;
        cyc = 1;
        while (fv2 !== 1'b1 && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        total++;
        if (cyc != 10) begin
            bad++;
            $display("FAIL cont_first: got %0d cycles want 10", cyc);
        end
        for (int k = 0; k < 5; k++) begin
            total++;
            if (sens2 != e || fault2 !== 4'd0) begin
                bad++;
                $display("FAIL cont_data%0d: got %h%h%h%h f=%b want %h%h%h%h f=0", k,
                         sens2[0], sens2[1], sens2[2], sens2[3], fault2, e[0], e[1], e[2], e[3]);
            end
            total++;
            if (busy2 !== 1'b1) begin
                bad++;
                $display("FAIL cont_busy%0d: got %b want 1", k, busy2);
            end
            for (int i = 0; i < 4; i++) begin
                val2[i] = 8'($urandom_range(0, 255));
                e[i]    = val2[i];
            end
            cyc = 0;
            do begin
                @(negedge clk);
                cyc++;
            end while (fv2 !== 1'b1 && cyc < 50);
            total++;
            if (cyc != 9) begin
                bad++;
                $display("FAIL cont_period%0d: got %0d cycles want 9", k, cyc);
            end
        end
    endtask

    initial begin
        rst    = 1'b1;
        start  = 1'b0;
        start2 = 1'b0;
        for (int i = 0; i < 4; i++) begin
            val[i]       = 8'd0;
            val2[i]      = 8'd0;
            delay_cfg[i] = 0;
            never_cfg[i] = 1'b0;
            stuck_cfg[i] = 1'b0;
        end
        repeat (3) @(negedge clk);
        test_reset();
        rst = 1'b0;
        test_basic();
        test_req_timeout();
        test_rel_timeout();
        test_start_ignored();
        test_reset_midframe();
        test_random();
        test_continuous();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
